// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: MDU op encodings, default latencies and FSM state type.
package mips_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_MADD  = 3'd6;
  localparam logic [2:0] MD_MADDU = 3'd7;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage to MDU bundle: request, operands, D-stage hazard hint, and HI/LO/busy/stall back.
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport slave  (input start, op, rs, rt, md_use, output busy, stall, hi, lo);
  modport master (output start, op, rs, rt, md_use, input busy, stall, hi, lo);
endinterface

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: 64-bit product, quotient/remainder, and the {hi,lo} accumulate
// that exists only when MDU_MADD_EN is defined.
module mdu_arith
  import mips_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o
);

  logic [63:0] prod_s, prod_u, res;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  // low 64 bits of the sign-extended product equal the signed 64-bit product
  assign prod_s = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
  assign prod_u = {32'b0, rs_i} * {32'b0, rt_i};

  // magnitude divide, then restore signs: quotient truncates toward zero, remainder follows dividend
  assign a_neg  = (op_i == MD_DIV) & rs_i[31];
  assign b_neg  = (op_i == MD_DIV) & rt_i[31];
  assign a_mag  = a_neg ? (32'd0 - rs_i) : rs_i;
  assign b_mag  = b_neg ? (32'd0 - rt_i) : rt_i;
  assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quo    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem    = a_neg ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    res = {hi_i, lo_i};
    case (op_i)
      MD_MULT:          res = prod_s;
      MD_MULTU:         res = prod_u;
      MD_DIV, MD_DIVU:  res = (rt_i == 32'd0) ? {hi_i, lo_i} : {rem, quo};
`ifdef MDU_MADD_EN
      MD_MADD:          res = {hi_i, lo_i} + prod_s;
      MD_MADDU:         res = {hi_i, lo_i} + prod_u;
`endif
      default:          res = {hi_i, lo_i};
    endcase
  end

  assign res_hi_o = res[63:32];
  assign res_lo_o = res[31:0];

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: HI/LO, fixed-latency busy counter and D-stage stall request.
// MDU_MADD_EN enables MADD/MADDU on ops 6/7.
//
// state   | meaning
// ST_IDLE | accepting MDU ops; MTHI/MTLO write immediately
// ST_MUL  | multiply/madd latency countdown, result pending
// ST_DIV  | divide latency countdown, result pending
module mdu_ctrl
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input logic       clk,
  input logic       reset,
  mdu_ctrl_if.slave md
);

  localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [31:0]      hi_q, lo_q, pend_hi_q, pend_lo_q;
  logic [31:0]      res_hi, res_lo;
  logic             is_mul, is_div, is_long;

  mdu_arith u_arith (
    .op_i     (md.op),
    .rs_i     (md.rs),
    .rt_i     (md.rt),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .res_hi_o (res_hi),
    .res_lo_o (res_lo)
  );

  always_comb begin
    is_div = (md.op == MD_DIV) || (md.op == MD_DIVU);
`ifdef MDU_MADD_EN
    is_mul  = (md.op == MD_MULT) || (md.op == MD_MULTU) || (md.op == MD_MADD) || (md.op == MD_MADDU);
    is_long = (md.op != MD_MTHI) && (md.op != MD_MTLO);
`else
    is_mul  = (md.op == MD_MULT) || (md.op == MD_MULTU);
    is_long = (md.op <= MD_DIVU);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (md.start) begin
            if (is_mul) begin
              pend_hi_q <= res_hi;
              pend_lo_q <= res_lo;
              cnt_q     <= CNT_W'(MULT_CYCLES);
              busy_q    <= 1'b1;
              state_q   <= ST_MUL;
            end else if (is_div) begin
              pend_hi_q <= res_hi;
              pend_lo_q <= res_lo;
              cnt_q     <= CNT_W'(DIV_CYCLES);
              busy_q    <= 1'b1;
              state_q   <= ST_DIV;
            end else if (md.op == MD_MTHI) begin
              hi_q <= md.rs;
            end else if (md.op == MD_MTLO) begin
              lo_q <= md.rs;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          // new starts are dropped here; the hazard unit should never issue one
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            hi_q    <= pend_hi_q;
            lo_q    <= pend_lo_q;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign md.busy  = busy_q;
  assign md.hi    = hi_q;
  assign md.lo    = lo_q;
  assign md.stall = md.md_use & (busy_q | (md.start & is_long));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with hand-computed HI/LO, busy length and stall expectations.
module tb_mdu_ctrl;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mdu_ctrl_if md();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md.start = 1'b1; md.op = op; md.rs = a; md.rt = b;
    step();
    md.start = 1'b0;
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (md.busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    md.start = 1'b0; md.op = MD_MULT; md.rs = '0; md.rt = '0; md.md_use = 1'b1;
    #3;
    checks++; if (md.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b want=0", md.busy); end
    checks++; if (md.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h want=0", md.hi); end
    checks++; if (md.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h want=0", md.lo); end
    checks++; if (md.stall !== 1'b0) begin errors++; $display("FAIL reset_stall_idle got=%0b want=0", md.stall); end
    md.start = 1'b1; md.rs = 32'h5; md.rt = 32'h5;
    #1;
    checks++; if (md.stall !== 1'b1) begin errors++; $display("FAIL reset_stall_start got=%0b want=1", md.stall); end
    step();
    checks++; if (md.busy !== 1'b0) begin errors++; $display("FAIL reset_hold_busy got=%0b want=0", md.busy); end
    md.start = 1'b0; md.md_use = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  task automatic test_mult();
    int n;
    issue(MD_MULT, 32'hFFFF_FFFF, 32'h2);
    checks++; if (md.busy !== 1'b1) begin errors++; $display("FAIL mult_busy_start got=%0b want=1", md.busy); end
    checks++; if (md.lo !== 32'h0) begin errors++; $display("FAIL mult_early_lo got=%h want=0", md.lo); end
    wait_idle(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL mult_busy_len got=%0d want=5", n); end
    checks++; if (md.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got=%h want=ffffffff", md.hi); end
    checks++; if (md.lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_lo got=%h want=fffffffe", md.lo); end
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'h2);
    wait_idle(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL multu_busy_len got=%0d want=5", n); end
    checks++; if (md.hi !== 32'h1) begin errors++; $display("FAIL multu_hi got=%h want=1", md.hi); end
    checks++; if (md.lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo got=%h want=fffffffe", md.lo); end
  endtask

  task automatic test_div();
    int n;
    issue(MD_DIV, 32'hFFFF_FFF9, 32'h2);
    wait_idle(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL div_busy_len got=%0d want=10", n); end
    checks++; if (md.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo got=%h want=fffffffd", md.lo); end
    checks++; if (md.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi got=%h want=ffffffff", md.hi); end
    issue(MD_DIVU, 32'h7, 32'h0);
    wait_idle(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL divz_busy_len got=%0d want=10", n); end
    checks++; if (md.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL divz_lo got=%h want=fffffffd", md.lo); end
    checks++; if (md.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_hi got=%h want=ffffffff", md.hi); end
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    checks++; if (md.lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got=%h want=80000000", md.lo); end
    checks++; if (md.hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got=%h want=0", md.hi); end
    issue(MD_DIV, 32'h7, 32'hFFFF_FFFE);
    wait_idle(n);
    checks++; if (md.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negdiv_lo got=%h want=fffffffd", md.lo); end
    checks++; if (md.hi !== 32'h1) begin errors++; $display("FAIL div_negdiv_hi got=%h want=1", md.hi); end
    issue(MD_DIVU, 32'd100, 32'd7);
    wait_idle(n);
    checks++; if (md.lo !== 32'd14) begin errors++; $display("FAIL divu_lo got=%h want=e", md.lo); end
    checks++; if (md.hi !== 32'd2) begin errors++; $display("FAIL divu_hi got=%h want=2", md.hi); end
  endtask

  task automatic test_stall_mt();
    int s;
    md.md_use = 1'b1;
    md.start = 1'b1; md.op = MD_MULT; md.rs = 32'd3; md.rt = 32'd5;
    #1;
    s = 0;
    while (md.stall === 1'b1 && s < 20) begin
      s++;
      step();
      md.start = 1'b0;
      #1;
    end
    checks++; if (s !== 6) begin errors++; $display("FAIL stall_len got=%0d want=6", s); end
    checks++; if (md.lo !== 32'd15 || md.hi !== 32'h0) begin errors++; $display("FAIL stall_mult_res got=%h:%h want=0:f", md.hi, md.lo); end
    md.start = 1'b1; md.op = MD_MTLO; md.rs = 32'h1234;
    #1;
    checks++; if (md.stall !== 1'b0) begin errors++; $display("FAIL mtlo_stall got=%0b want=0", md.stall); end
    step();
    md.start = 1'b0;
    checks++; if (md.lo !== 32'h1234) begin errors++; $display("FAIL mtlo_lo got=%h want=1234", md.lo); end
    checks++; if (md.busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy got=%0b want=0", md.busy); end
    issue(MD_MTHI, 32'hABCD, 32'h0);
    checks++; if (md.hi !== 32'hABCD || md.lo !== 32'h1234) begin errors++; $display("FAIL mthi got=%h:%h want=abcd:1234", md.hi, md.lo); end
    md.md_use = 1'b0;
  endtask

  task automatic test_busy_ignore();
    int n;
    issue(MD_MULT, 32'd6, 32'd7);
    checks++; if (md.stall !== 1'b0) begin errors++; $display("FAIL busy_nouse_stall got=%0b want=0", md.stall); end
    n = 0;
    while (md.busy === 1'b1 && n < 40) begin
      n++;
      if (n == 2) begin md.start = 1'b1; md.op = MD_DIV; md.rs = 32'd100; md.rt = 32'd3; end
      else if (n == 3) begin md.start = 1'b1; md.op = MD_MTLO; md.rs = 32'hDEAD; end
      else md.start = 1'b0;
      step();
    end
    md.start = 1'b0;
    checks++; if (n !== 5) begin errors++; $display("FAIL ignore_busy_len got=%0d want=5", n); end
    checks++; if (md.hi !== 32'h0 || md.lo !== 32'd42) begin errors++; $display("FAIL ignore_res got=%h:%h want=0:2a", md.hi, md.lo); end
    step();
    checks++; if (md.busy !== 1'b0) begin errors++; $display("FAIL ignore_no_div got=%0b want=0", md.busy); end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(MD_MULT, 32'd2, 32'd3);
    wait_idle(n);
    checks++; if (md.lo !== 32'd6) begin errors++; $display("FAIL b2b_first_lo got=%h want=6", md.lo); end
    issue(MD_MULTU, 32'h1_0000, 32'h1_0000);
    checks++; if (md.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%0b want=1", md.busy); end
    wait_idle(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL b2b_busy_len got=%0d want=5", n); end
    checks++; if (md.hi !== 32'h1 || md.lo !== 32'h0) begin errors++; $display("FAIL b2b_res got=%h:%h want=1:0", md.hi, md.lo); end
  endtask

  task automatic test_op67();
`ifdef MDU_MADD_EN
    int n;
    issue(MD_MTHI, 32'h0, 32'h0);
    issue(MD_MTLO, 32'hFFFF_FFFF, 32'h0);
    md.md_use = 1'b1; md.start = 1'b1; md.op = MD_MADD;
    #1;
    checks++; if (md.stall !== 1'b1) begin errors++; $display("FAIL madd_stall got=%0b want=1", md.stall); end
    md.md_use = 1'b0; md.start = 1'b0;
    issue(MD_MADDU, 32'h1, 32'h1);
    wait_idle(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL maddu_busy_len got=%0d want=5", n); end
    checks++; if (md.hi !== 32'h1 || md.lo !== 32'h0) begin errors++; $display("FAIL maddu_res got=%h:%h want=1:0", md.hi, md.lo); end
`else
    issue(MD_MADD, 32'h5, 32'h5);
    checks++; if (md.busy !== 1'b0) begin errors++; $display("FAIL rsvd_busy got=%0b want=0", md.busy); end
    checks++; if (md.hi !== 32'h1 || md.lo !== 32'h0) begin errors++; $display("FAIL rsvd_hilo got=%h:%h want=1:0", md.hi, md.lo); end
    md.md_use = 1'b1; md.start = 1'b1; md.op = MD_MADDU;
    #1;
    checks++; if (md.stall !== 1'b0) begin errors++; $display("FAIL rsvd_stall got=%0b want=0", md.stall); end
    md.md_use = 1'b0; md.start = 1'b0;
    step();
`endif
  endtask

  task automatic test_reset_mid();
    int n;
    issue(MD_MTLO, 32'h55, 32'h0);
    issue(MD_DIV, 32'd20, 32'd3);
    repeat (3) step();
    checks++; if (md.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got=%0b want=1", md.busy); end
    #2 reset = 1'b0;
    #1;
    checks++; if (md.busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%0b want=0", md.busy); end
    checks++; if (md.hi !== 32'h0 || md.lo !== 32'h0) begin errors++; $display("FAIL mid_hilo got=%h:%h want=0:0", md.hi, md.lo); end
    @(negedge clk);
    reset = 1'b1;
    step();
    checks++; if (md.busy !== 1'b0) begin errors++; $display("FAIL mid_after_busy got=%0b want=0", md.busy); end
    issue(MD_DIV, 32'd20, 32'd3);
    wait_idle(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL mid_redo_len got=%0d want=10", n); end
    checks++; if (md.lo !== 32'd6 || md.hi !== 32'd2) begin errors++; $display("FAIL mid_redo_res got=%h:%h want=2:6", md.hi, md.lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_stall_mt();
    test_busy_ignore();
    test_back_to_back();
    test_op67();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the pipelined MIPS core. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage, holds HI/LO, and models fixed multi-cycle latency with a busy counter. Drives the stall request the hazard unit uses to freeze D while an MDU-dependent instruction would otherwise issue. Sits beside the ALU in E, fed by forwarded rs/rt values.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU (≥1).
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU (≥1).
- `clk` input, 1: system clock, rising edge.
- `reset` input, 1: asynchronous, active-low reset.
- `start` input, 1: E-stage MDU instruction valid this cycle.
- `op` input, 3: `MD_MULT`=0, `MD_MULTU`=1, `MD_DIV`=2, `MD_DIVU`=3, `MD_MTHI`=4, `MD_MTLO`=5 (6/7 reserved, see Configuration).
- `rs` input, 32: forwarded operand A.
- `rt` input, 32: forwarded operand B.
- `md_use` input, 1: D-stage instruction is MDU-class (mult/div/mthi/mtlo/mfhi/mflo).
- `busy` output, 1: multi-cycle operation in flight.
- `stall` output, 1: combinational, `md_use & (busy | (start & op<=MD_DIVU))`.
- `hi` output, 32: HI register.
- `lo` output, 32: LO register.

## Operation
- States: IDLE, MUL, DIV. Down-counter `cnt` (width ⌈log2(max(MULT_CYCLES,DIV_CYCLES)+1)⌉).
- IDLE, `start` with MULT/MULTU: capture 64-bit product of rs×rt (signed/unsigned) into pending regs; `cnt`←MULT_CYCLES; →MUL.
- IDLE, `start` with DIV/DIVU: pending LO←quotient, HI←remainder (signed: truncate toward zero, remainder takes dividend sign); `cnt`←DIV_CYCLES; →DIV.
- Divide by zero: pending←current hi/lo (registers unchanged at commit); full DIV_CYCLES busy still spent.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- IDLE, `start` with MTHI/MTLO: hi (or lo)←rs at that edge; no busy.
- MUL/DIV: `cnt` decrements each edge; on the edge where `cnt`==1, hi/lo←pending, →IDLE.
- `start` while busy: ignored (no state, hi/lo or counter change). Hazard unit guarantees this does not occur; bench checks it is harmless.
- Reserved op codes with macro off: ignored, treated as no `start`.

## Timing
- Reset (async assert, any state incl. mid-operation): state IDLE, `cnt`=0, `busy`=0, `hi`=0, `lo`=0, pending discarded. `stall` then follows `md_use & start` only.
- `busy` is 1 for exactly N cycles, starting the cycle after the accepting edge; hi/lo new values visible the cycle `busy` falls.
- Back-to-back: a new `start` in the first cycle `busy`=0 is accepted; an MFHI reading in that cycle sees the committed value.
- `stall` is combinational, asserted in the accepting cycle itself, so an MFHI in D directly behind MULT stalls for 1+N cycles total.
- MTHI/MTLO: 1-cycle, no stall contribution.

## Configuration
- `MDU_MADD_EN` defined: op 6 = MADD, op 7 = MADDU; pending {hi,lo}←{hi,lo}+rs×rt (signed/unsigned, 64-bit wrap), latency MULT_CYCLES, counted in `stall`'s op test (`op!=MTHI/MTLO`).
- Undefined: ops 6/7 ignored; no accumulator adder synthesized.

## Structure
- Shared package `mips_pkg`: `MD_*` op encodings, default latencies.
- One sub-module natural: `mdu_arith` (combinational 64-bit product/quotient/remainder, optional MADD adder); `mdu_ctrl` holds FSM, counter, pending and HI/LO regs.

## Test plan
- Reset mid-DIV (assert at cycle 4 of 10) → busy=0, hi=lo=0 immediately; next DIV runs full 10 cycles.
- MULT rs=0xFFFFFFFF, rt=2 → busy 5 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU same → hi=1, lo=0xFFFFFFFE.
- DIV rs=-7, rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles; DIVU 7/0 → hi/lo unchanged.
- MULT then md_use=1 held → stall high 6 consecutive cycles, low once busy falls; MTLO rs=0x1234 → lo=0x1234 next cycle, stall 0.
- `start` DIV while MUL busy → ignored; MUL result committed at its cycle 5, busy drops on schedule.
- `MDU_MADD_EN`: hi:lo=0:0xFFFFFFFF, MADDU 1×1 → hi=1, lo=0 after 5 cycles.
